// File: rtl/lzc_normalizer.sv
// Two-stage valid/ready normalizer: counts leading zeros, shifts the mantissa
// up to a leading 1 and lowers the exponent, clamping the shift at exponent 0.
module lzc_normalizer #(
  parameter int unsigned N  = 8,
  parameter int unsigned EW = 8,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic [CW-1:0] out_lzc,
  output logic          out_zero,
  output logic          out_uflow
);

  logic          s1_valid_q, s1_valid_d;
  logic [N-1:0]  s1_mant_q;
  logic [EW-1:0] s1_exp_q;
  logic [CW-1:0] s1_lz_q;

  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  s2_mant_q, s2_mant_d;
  logic [EW-1:0] s2_exp_q, s2_exp_d;
  logic [CW-1:0] s2_lzc_q, s2_lzc_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_uflow_q, s2_uflow_d;

  logic          in_accept;
  logic          s2_load;
  logic [CW-1:0] lz_c;
  logic          lz_found;
  logic [EW-1:0] lz_ext;
  logic [EW-1:0] shift;
  logic          s1_zero;

  assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_accept = in_valid && in_ready;
  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);

  // Leading-zero count of the incoming mantissa; N when all bits are zero.
  always_comb begin
    lz_c     = CW'(N);
    lz_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!lz_found && in_mant[i]) begin
        lz_c     = CW'(int'(N) - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Normalization of the S1 beat into the S2 result fields.
  always_comb begin
    s1_zero    = (s1_mant_q == '0);
    lz_ext     = EW'(s1_lz_q);
    shift      = (lz_ext < s1_exp_q) ? lz_ext : s1_exp_q;
    s2_mant_d  = s1_mant_q << shift;
    s2_exp_d   = s1_exp_q - shift;
    s2_lzc_d   = s1_lz_q;
    s2_zero_d  = 1'b0;
    s2_uflow_d = (lz_ext > s1_exp_q);
    if (s1_zero) begin
      s2_mant_d  = '0;
      s2_exp_d   = '0;
      s2_lzc_d   = CW'(N);
      s2_zero_d  = 1'b1;
      s2_uflow_d = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_lzc_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_accept) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_lz_q   <= lz_c;
      end
      if (s2_load) begin
        s2_mant_q  <= s2_mant_d;
        s2_exp_q   <= s2_exp_d;
        s2_lzc_q   <= s2_lzc_d;
        s2_zero_q  <= s2_zero_d;
        s2_uflow_q <= s2_uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = s2_mant_q;
  assign out_exp   = s2_exp_q;
  assign out_lzc   = s2_lzc_q;
  assign out_zero  = s2_zero_q;
  assign out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed bench for lzc_normalizer: hand-computed single beats, backpressured
// and full-rate streams against a reference model, and mid-stream reset.
module tb_lzc_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mant;
  logic [7:0] in_exp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [7:0] out_exp;
  logic [3:0] out_lzc;
  logic       out_zero;
  logic       out_uflow;
  logic [21:0] outvec;

  int n_tests = 0;
  int n_fail  = 0;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  assign outvec = {out_mant, out_exp, out_lzc, out_zero, out_uflow};

  lzc_normalizer #(.N(8), .EW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_lzc(out_lzc), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference result packed as {mant, exp, lzc, zero, uflow}.
  function automatic logic [21:0] model(input logic [7:0] m, input logic [7:0] e);
    int lz;
    int sh;
    logic [7:0] om;
    logic [7:0] oe;
    lz = 8;
    for (int i = 0; i < 8; i++) if (m[i]) lz = 7 - i;
    if (m == 8'h00) return {8'h00, 8'h00, 4'd8, 1'b1, 1'b0};
    sh = (lz < int'(e)) ? lz : int'(e);
    om = m << sh;
    oe = e - 8'(sh);
    return {om, oe, 4'(lz), 1'b0, (lz > int'(e))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [7:0] m, input logic [7:0] e,
                        input logic [21:0] want);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mant   = m;
    in_exp    = e;
    #3;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(outvec), 32'(want));
    tick();
  endtask

  task automatic run_stream(input string tag, input int nbeats, input bit bp, input bit rnd);
    logic [21:0] q[$];
    logic [21:0] held;
    logic [7:0]  cur_m;
    logic [7:0]  cur_e;
    logic        hold;
    logic        acc;
    logic        tk;
    int sent = 0, recv = 0, cyc = 0;
    int first_acc = -1, first_out = -1, last_out = -1;
    hold  = 1'b0;
    held  = '0;
    cur_m = rnd ? 8'($urandom) : 8'd1;
    cur_e = rnd ? 8'($urandom_range(0, 12)) : 8'd3;
    while (recv < nbeats && cyc < 400) begin
      out_ready = bp ? (pat[cyc % 6] != 0) : 1'b1;
      in_valid  = (sent < nbeats);
      in_mant   = cur_m;
      in_exp    = cur_e;
      #3;
      if (hold) check({tag, "_stable"}, 32'(outvec), 32'(held));
      if (!in_ready) check({tag, "_in_ready_low"}, 32'({out_valid, out_ready}), 32'b10);
      acc  = in_valid && in_ready;
      tk   = out_valid && out_ready;
      hold = out_valid && !out_ready;
      held = outvec;
      if (tk) begin
        if (q.size() == 0) check({tag, "_spurious"}, 32'd1, 32'd0);
        else check({tag, "_beat"}, 32'(outvec), 32'(q.pop_front()));
        if (first_out < 0) first_out = cyc;
        if (!bp && last_out >= 0) check({tag, "_gap"}, 32'(cyc - last_out), 32'd1);
        last_out = cyc;
        recv++;
      end
      if (acc) begin
        q.push_back(model(cur_m, cur_e));
        if (first_acc < 0) first_acc = cyc;
        sent++;
        cur_m = rnd ? 8'($urandom) : 8'(sent + 1);
        cur_e = rnd ? 8'($urandom_range(0, 12)) : 8'(3 + sent % 4);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_recv_count"}, 32'(recv), 32'(nbeats));
    check({tag, "_leftover"}, 32'(q.size()), 32'd0);
    if (!bp) check({tag, "_latency"}, 32'(first_out - first_acc), 32'd2);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'(outvec), 32'd0);
    tick();

    single("basic", 8'b0010_1000, 8'd10, {8'b1010_0000, 8'd8, 4'd2, 1'b0, 1'b0});
    single("zero", 8'h00, 8'd5, {8'h00, 8'd0, 4'd8, 1'b1, 1'b0});
    single("full_scale", 8'h80, 8'd3, {8'h80, 8'd3, 4'd0, 1'b0, 1'b0});
    single("uflow", 8'b0000_0011, 8'd2, {8'b0000_1100, 8'd0, 4'd6, 1'b0, 1'b1});
    single("exact_fit", 8'h01, 8'd7, {8'h80, 8'd0, 4'd7, 1'b0, 1'b0});

    run_stream("bp", 16, 1'b1, 1'b0);
    run_stream("full", 100, 1'b0, 1'b1);

    // Fill both stages, then reset while a new beat is also offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 8'h11;
    in_exp    = 8'd5;
    tick();
    in_mant = 8'h22;
    tick();
    out_ready = 1'b1;
    in_mant   = 8'h33;
    rst       = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_stale", 32'(out_valid), 32'd0);
      tick();
    end
    single("after_rst", 8'h40, 8'd1, {8'h80, 8'd0, 4'd1, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
